switch_out_arbiter: RTL and testbench
=====================================

Name: switch_out_arbiter

Overview:
- Per-output-port round-robin arbiter inside switch_4port; one instance per output port, OUT_IDX selects which.
- Inspects the head entry of all four ingress packet FIFOs and grants one whose target bit OUT_IDX is set.
- Pops the granted FIFO and registers the packet onto the port's valid_out/source_out/target_out/data_out.
- Honours downstream out_ready backpressure; keeps delivered-packet and stall counters.

Parameters:
- OUT_IDX, 0, output port index served by this instance (0..3).
- DATA_W, 8, packet data width.
- SRC_W, 4, source field width (one-hot port id).
- TGT_W, 4, target field width (one-hot port id).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- head_valid  in  4  bit i: ingress FIFO i non-empty
- head_source  in  4*SRC_W  FIFO i head source at [i*SRC_W +: SRC_W]
- head_target  in  4*TGT_W  FIFO i head target, same packing
- head_data  in  4*DATA_W  FIFO i head data, same packing
- pop  out  4  one-hot combinational pop strobe to FIFO i
- out_ready  in  1  downstream accepts the output packet this cycle
- valid_out  out  1  output packet valid
- source_out  out  SRC_W  output packet source
- target_out  out  TGT_W  output packet target
- data_out  out  DATA_W  output packet data
- pkt_count  out  CNT_W  packets accepted downstream, saturating
- stall_count  out  CNT_W  cycles with valid_out=1 and out_ready=0, saturating

Behaviour:
- Reset (async assert, sync release): valid_out=0, source_out/target_out/data_out=0, rr_ptr=0, pkt_count=0, stall_count=0. pop forced to 0 while rst=1.
- Request: req[i] = head_valid[i] & head_target[i][OUT_IDX]. Other target bits ignored. Upstream guarantees one-hot targets; multicast unsupported.
- Output register FSM:
  - EMPTY (valid_out=0).
  - FULL (valid_out=1).
  - Slot free when EMPTY, or FULL with out_ready=1.
- Grant: when slot free and req!=0, winner = first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod 4.
  - pop[winner]=1 in the same cycle (combinational; FIFO pops on that edge).
  - On the edge: output register loads the winner's head fields, valid_out=1, rr_ptr <= winner+1 mod 4.
- Slot free with req=0: FULL->EMPTY if out_ready=1; fields hold last values; rr_ptr unchanged.
- FULL and out_ready=0: pop=0; all output fields held stable; stall_count++.
- Latency: head present to valid_out is 1 cycle. Throughput: 1 packet/cycle with out_ready=1. Accepted packet and new load in the same cycle are allowed (back-to-back).
- pkt_count increments on each cycle valid_out=1 & out_ready=1.
- Counters saturate at all-ones and never wrap.
- At most one pop bit set. Pop never asserted for an input without req.
- Reset mid-operation: the in-flight output packet is dropped; no pop is issued in the reset cycle.

Test Plan:
- OUT_IDX=1, head_valid=4'b0100, head_target[2]=4'b0010, data 0xA5, source 4'b0100, out_ready=1: pop=4'b0100 that cycle; next cycle valid_out=1, data_out=0xA5, source_out=4'b0100, target_out=4'b0010; pkt_count=1.
- All four heads valid targeting port 1, out_ready=1 for 8 cycles: grants 0,1,2,3,0,1,2,3 on consecutive cycles; valid_out continuously 1; pkt_count=8.
- valid_out=1 with data 0x3C, out_ready=0 for 3 cycles, head 0 requesting: data_out holds 0x3C, pop=0 all 3 cycles, stall_count=3. On out_ready=1: input 0 popped, pkt_count+1.
- head_valid=4'b1111, all targets 4'b0100, OUT_IDX=1: pop stays 0, valid_out stays 0, counters unchanged.
- Stream running with rr_ptr=2, rst pulsed mid-cycle: valid_out=0 immediately, counters 0. After release with req on inputs 0 and 3: input 0 granted first, then input 3.
- stall_count preloaded near 0xFFFF via a long out_ready=0 run: value saturates at 0xFFFF, does not wrap.

Source files
------------

// File: rtl/switch_out_arbiter_if.sv
// ---------------------------------------------------------------------------
// switch_out_arbiter_if : ingress FIFO heads/pops and egress packet bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface switch_out_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int SRC_W  = 4,
  parameter int TGT_W  = 4
);
  logic [3:0]          head_valid;
  logic [4*SRC_W-1:0]  head_source;
  logic [4*TGT_W-1:0]  head_target;
  logic [4*DATA_W-1:0] head_data;
  logic [3:0]          pop;
  logic                out_ready;
  logic                valid_out;
  logic [SRC_W-1:0]    source_out;
  logic [TGT_W-1:0]    target_out;
  logic [DATA_W-1:0]   data_out;

  modport master (
    input  head_valid, head_source, head_target, head_data, out_ready,
    output pop, valid_out, source_out, target_out, data_out
  );

  modport slave (
    output head_valid, head_source, head_target, head_data, out_ready,
    input  pop, valid_out, source_out, target_out, data_out
  );
endinterface

`default_nettype wire

// File: rtl/switch_out_arbiter.sv
// ---------------------------------------------------------------------------
// switch_out_arbiter : round-robin grant of 4 ingress heads onto one output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module switch_out_arbiter #(
  parameter int OUT_IDX = 0,
  parameter int DATA_W  = 8,
  parameter int SRC_W   = 4,
  parameter int TGT_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  switch_out_arbiter_if.master  bus,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t            r_state, w_state_next;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        w_winner;
  logic [3:0]        w_req;
  logic [3:0]        w_pop;
  logic              w_any_req;
  logic              w_slot_free;
  logic              w_load;
  logic [SRC_W-1:0]  r_source;
  logic [TGT_W-1:0]  r_target;
  logic [DATA_W-1:0] r_data;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      assign w_req[gi] = bus.head_valid[gi] & bus.head_target[gi*TGT_W + OUT_IDX];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
  always_comb begin : p_winner
    logic [1:0] idx;
    w_any_req = 1'b0;
    w_winner  = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = r_rr_ptr + 2'(k);
      if (w_req[idx]) begin
        w_any_req = 1'b1;
        w_winner  = idx;
      end
    end
  end

  assign w_slot_free = (r_state == EMPTY) || bus.out_ready;
  assign w_load      = w_slot_free && w_any_req;

  always_comb begin : p_fsm_next
    w_state_next = r_state;
    w_pop        = 4'b0000;
    case (r_state)
      EMPTY:   if (w_any_req) w_state_next = FULL;
      FULL:    if (bus.out_ready && !w_any_req) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
    if (w_load && !rst) w_pop = 4'b0001 << w_winner;
  end

  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin : p_datapath
    if (rst) begin
      r_source <= '0;
      r_target <= '0;
      r_data   <= '0;
      r_rr_ptr <= 2'd0;
    end else if (w_load) begin
      r_source <= bus.head_source[int'(w_winner)*SRC_W +: SRC_W];
      r_target <= bus.head_target[int'(w_winner)*TGT_W +: TGT_W];
      r_data   <= bus.head_data[int'(w_winner)*DATA_W +: DATA_W];
      r_rr_ptr <= w_winner + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_counters
    if (rst) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else if (r_state == FULL) begin
      if (bus.out_ready) begin
        if (pkt_count != C_CNT_MAX) pkt_count <= pkt_count + 1'b1;
      end else begin
        if (stall_count != C_CNT_MAX) stall_count <= stall_count + 1'b1;
      end
    end
  end

  assign bus.pop        = w_pop;
  assign bus.valid_out  = (r_state == FULL);
  assign bus.source_out = r_source;
  assign bus.target_out = r_target;
  assign bus.data_out   = r_data;

endmodule

`default_nettype wire

// File: tb/tb_switch_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_switch_out_arbiter : directed checks of switch_out_arbiter, OUT_IDX = 1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_switch_out_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] pkt_count;
  logic [15:0] stall_count;
  int          n_checks;
  int          n_errors;

  switch_out_arbiter_if #(.DATA_W(8), .SRC_W(4), .TGT_W(4)) bus ();

  switch_out_arbiter #(
    .OUT_IDX (1),
    .DATA_W  (8),
    .SRC_W   (4),
    .TGT_W   (4),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .pkt_count   (pkt_count),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input int i, input logic v, input logic [3:0] src,
                          input logic [3:0] tgt, input logic [7:0] data);
    bus.head_valid[i]          = v;
    bus.head_source[i*4 +: 4]  = src;
    bus.head_target[i*4 +: 4]  = tgt;
    bus.head_data[i*8 +: 8]    = data;
  endtask

  task automatic clear_heads();
    bus.head_valid  = 4'b0000;
    bus.head_source = '0;
    bus.head_target = '0;
    bus.head_data   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    clear_heads();

    // Reset state, with a requesting head present
    set_head(2, 1'b1, 4'b0100, 4'b0010, 8'hA5);
    #1;
    check("rst_pop",   32'(bus.pop), 32'h0);
    step();
    step();
    check("rst_valid", 32'(bus.valid_out), 32'h0);
    check("rst_data",  32'(bus.data_out), 32'h0);
    check("rst_src",   32'(bus.source_out), 32'h0);
    check("rst_pkt",   32'(pkt_count), 32'h0);
    check("rst_stall", 32'(stall_count), 32'h0);

    // Single packet from input 2
    rst = 1'b0;
    #1;
    check("t1_pop", 32'(bus.pop), 32'h4);
    step();
    bus.head_valid = 4'b0000;
    #1;
    check("t1_valid", 32'(bus.valid_out), 32'h1);
    check("t1_data",  32'(bus.data_out), 32'hA5);
    check("t1_src",   32'(bus.source_out), 32'h4);
    check("t1_tgt",   32'(bus.target_out), 32'h2);
    step();
    check("t1_pkt",    32'(pkt_count), 32'h1);
    check("t1_empty",  32'(bus.valid_out), 32'h0);

    // Round-robin over four continuously requesting inputs
    do_reset();
    for (int i = 0; i < 4; i++)
      set_head(i, 1'b1, 4'(1 << i), 4'b0010, 8'(8'h10 + i));
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_pop%0d", k), 32'(bus.pop), 32'(1 << (k % 4)));
      step();
      check($sformatf("t2_valid%0d", k), 32'(bus.valid_out), 32'h1);
      check($sformatf("t2_data%0d", k), 32'(bus.data_out), 32'(8'h10 + (k % 4)));
    end
    clear_heads();
    step();
    check("t2_pkt",   32'(pkt_count), 32'd8);
    check("t2_stall", 32'(stall_count), 32'd0);

    // Backpressure: hold 0x3C for three stalled cycles
    do_reset();
    set_head(0, 1'b1, 4'b0001, 4'b0010, 8'h3C);
    #1;
    check("t3_pop_load", 32'(bus.pop), 32'h1);
    step();
    set_head(0, 1'b1, 4'b0001, 4'b0010, 8'h77);
    bus.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t3_pop_stall%0d", k), 32'(bus.pop), 32'h0);
      check($sformatf("t3_hold%0d", k), 32'(bus.data_out), 32'h3C);
      step();
    end
    check("t3_stall", 32'(stall_count), 32'd3);
    check("t3_pkt0",  32'(pkt_count), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("t3_pop_release", 32'(bus.pop), 32'h1);
    step();
    clear_heads();
    #1;
    check("t3_pkt1",  32'(pkt_count), 32'd1);
    check("t3_next",  32'(bus.data_out), 32'h77);
    step();

    // Heads targeting another port are ignored
    do_reset();
    for (int i = 0; i < 4; i++)
      set_head(i, 1'b1, 4'(1 << i), 4'b0100, 8'(8'h50 + i));
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t4_pop%0d", k), 32'(bus.pop), 32'h0);
      check($sformatf("t4_valid%0d", k), 32'(bus.valid_out), 32'h0);
      step();
    end
    check("t4_pkt",   32'(pkt_count), 32'd0);
    check("t4_stall", 32'(stall_count), 32'd0);

    // Reset mid-stream with rr_ptr at 2
    do_reset();
    clear_heads();
    set_head(1, 1'b1, 4'b0010, 4'b0010, 8'h11);
    #1;
    step();
    step();
    step();
    check("t5_running", 32'(bus.valid_out), 32'h1);
    check("t5_pkt_pre", 32'(pkt_count), 32'd2);
    #3;
    rst = 1'b1;
    clear_heads();
    set_head(0, 1'b1, 4'b0001, 4'b0010, 8'hA0);
    set_head(3, 1'b1, 4'b1000, 4'b0010, 8'hD3);
    #1;
    check("t5_rst_valid", 32'(bus.valid_out), 32'h0);
    check("t5_rst_pkt",   32'(pkt_count), 32'd0);
    check("t5_rst_pop",   32'(bus.pop), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("t5_pop_first", 32'(bus.pop), 32'h1);
    step();
    check("t5_data_first", 32'(bus.data_out), 32'hA0);
    bus.head_valid[0] = 1'b0;
    #1;
    check("t5_pop_second", 32'(bus.pop), 32'h8);
    step();
    check("t5_data_second", 32'(bus.data_out), 32'hD3);
    clear_heads();
    step();

    // stall_count saturates
    do_reset();
    set_head(0, 1'b1, 4'b0001, 4'b0010, 8'hE7);
    #1;
    step();
    clear_heads();
    bus.out_ready = 1'b0;
    repeat (65540) step();
    check("t6_stall_sat", 32'(stall_count), 32'hFFFF);
    check("t6_hold",      32'(bus.data_out), 32'hE7);
    check("t6_valid",     32'(bus.valid_out), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
